rob_commit_unit: RTL and testbench
==================================

# rob_commit_unit

In-order retirement stage for the out-of-order datapath. It reads the reorder-buffer head entry that the dispatch and writeback side has filled and completed. It commits the entry's architectural effects: register write, flag update, and store release to data memory. On a mispredicted branch it raises a pipeline flush with the correct redirect PC. It sits between the ROB and the register file, flag register, data memory port and fetch PC.

## Interface
Parameters:
- ROBsize, 8, ROB depth; power of two.
- DATA_W, 64, register and memory data width.
- ADDR_W, 64, PC and memory address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; 0 = reset.
- head_valid  in  1  ROB head holds an allocated entry.
- head_done  in  1  head entry has completed execution.
- head_regWrite  in  1  entry writes a register.
- head_rd  in  5  destination register.
- head_value  in  DATA_W  result value.
- head_saveCond  in  1  entry updates flags.
- head_flags  in  4  {negative, zero, overflow, carry_out}.
- head_isStore  in  1  entry is a store.
- head_stAddr  in  ADDR_W  store address.
- head_stData  in  DATA_W  store data.
- head_mispredict  in  1  branch resolved opposite to prediction.
- head_target  in  ADDR_W  correct next PC for a mispredicted branch.
- rob_pop  out  1  combinational; head retires this cycle.
- rf_we, rf_waddr[5], rf_wdata[DATA_W]  out  registered register-file write.
- flags_we, flags_o[4]  out  registered flag-register write.
- mem_req, mem_addr[ADDR_W], mem_wdata[DATA_W]  out  registered store request.
- mem_ack  in  1  memory accepted the store.
- flush  out  1  registered; one-cycle pipeline flush.
- redirect_pc  out  ADDR_W  valid while flush = 1.
- retired_count  out  32  instructions retired since reset.

## Operation
- FSM states: RUN, STORE_WAIT, FLUSH. The reset state is RUN.
- RUN with head_valid & head_done:
  - Non-store: rob_pop = 1.
  - Next cycle: rf_we = head_regWrite and flags_we = head_saveCond, with the captured rd, value and flags.
  - If head_mispredict, flush = 1 and redirect_pc = head_target on the next cycle, and the FSM moves to FLUSH.
- RUN, head is a store: the unit does not pop. It drives mem_req = 1 next cycle with the captured addr and data, and moves to STORE_WAIT.
- STORE_WAIT:
  - mem_req, mem_addr and mem_wdata hold stable until mem_ack.
  - The cycle mem_ack = 1: rob_pop = 1, and mem_req drops next cycle. A store with regWrite or saveCond performs those writes on that following cycle. The FSM returns to RUN.
  - mem_ack while mem_req = 0 is ignored.
- FLUSH: lasts exactly one cycle. rob_pop = 0 and no commit, because the ROB is clearing. The FSM then returns to RUN.
- Head not valid or not done: no pop. All write enables are 0 next cycle.
- Register 0 is not special-cased here. The register file handles it.
- retired_count increments by 1 on every rob_pop and wraps at 2^32.

## Timing
- Throughput is one retirement per cycle for non-store entries.
- Commit latency is 1 cycle, from the pop cycle to the rf_we, flags_we and flush outputs.
- Store commit takes at least 2 cycles: the request cycle, then the ack cycle. Latency is unbounded while mem_ack stays low.
- Reset values:
  - All outputs 0: rob_pop, rf_we, flags_we, mem_req, flush, and every data bus.
  - retired_count = 0.
  - State = RUN.
- Reset has priority over every event. Reset asserted in STORE_WAIT drops mem_req on the next edge and abandons the store.
- A mispredicted store is not legal. Branch entries never set isStore; the bench flags this with an assertion.
- A pop and a flush never refer to different entries. The flush always describes the entry popped on the prior cycle.

## Structure
- Shared package rob_pkg:
  - rob_entry_t struct with the head fields above.
  - commit_state_e enum {RUN, STORE_WAIT, FLUSH}.
  - FLAG_* bit-index constants.
- The head inputs are packed into rob_entry_t at the ROB boundary.
- One sub-module: commit_fsm, holding the state register plus the rob_pop and mem_req decisions. The write-capture registers and the counter live in the top.

## Test plan
- Two back-to-back ALU entries are ready:
  - Entry A: rd = 3, value = 0x10, regWrite.
  - Entry B: rd = 4, value = 0x20, regWrite, saveCond, flags = 0b0100.
  - Required: rob_pop high 2 consecutive cycles; rf writes (3,0x10) then (4,0x20); flags_we only on the second; retired_count = 2.
- Store at addr 0x80, data 0xDEAD, with mem_ack after 3 cycles:
  - Required: mem_req held 3 cycles with stable addr and data.
  - Required: rob_pop exactly once, on the ack cycle; mem_req low the next cycle.
- Mispredicted branch with target 0x400:
  - Required: pop, then flush = 1 with redirect_pc = 0x400 for exactly 1 cycle.
  - Required: a ready entry presented during FLUSH is not popped.
- head_valid = 1 with head_done = 0 for 5 cycles, then done:
  - Required: no pop and no writes during the wait; commit occurs the cycle done rises.
- reset = 0 asserted in STORE_WAIT:
  - Required: mem_req = 0, all outputs 0 and retired_count = 0 after the next edge; the FSM is in RUN.
- Count-wrap check: the counter is forced to 0xFFFFFFFF, then one commit is made → retired_count = 0.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types for the in-order retirement stage.
// Head-entry bundle, commit FSM states and flag bit positions.
package rob_pkg;

  localparam int XLEN   = 64;
  localparam int FLAG_W = 4;

  // Flag vector layout: {negative, zero, overflow, carry_out}
  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STORE_WAIT = 2'd1,
    FLUSH      = 2'd2
  } commit_state_e;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              reg_write;
    logic [4:0]        rd;
    logic [XLEN-1:0]   value;
    logic              save_cond;
    logic [FLAG_W-1:0] flags;
    logic              is_store;
    logic [XLEN-1:0]   st_addr;
    logic [XLEN-1:0]   st_data;
    logic              mispredict;
    logic [XLEN-1:0]   target;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit_unit_fsm.sv
// Commit FSM: RUN / STORE_WAIT / FLUSH state register plus the
// pop and store-request decisions.
// Ports: clk, reset_ni (sync, active-low), rdy_i (head valid&done),
//   store_i, mis_i, mem_ack_i -> pop_o, st_start_o, mem_req_o.
module commit_fsm
  import rob_pkg::*;
(
  input  logic clk,
  input  logic reset_ni,
  input  logic rdy_i,
  input  logic store_i,
  input  logic mis_i,
  input  logic mem_ack_i,
  output logic pop_o,
  output logic st_start_o,
  output logic mem_req_o
);

  commit_state_e state_q, state_d;
  logic          req_q, req_d;
  logic          pop;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    pop        = 1'b0;
    st_start_o = 1'b0;
    unique case (state_q)
      RUN: begin
        if (rdy_i) begin
          if (store_i) begin
            st_start_o = 1'b1;
            req_d      = 1'b1;
            state_d    = STORE_WAIT;
          end else begin
            pop = 1'b1;
            if (mis_i) state_d = FLUSH;
          end
        end
      end
      STORE_WAIT: begin
        // ack only counts while a request is outstanding
        if (mem_ack_i && req_q) begin
          pop     = 1'b1;
          req_d   = 1'b0;
          state_d = RUN;
        end
      end
      FLUSH: begin
        // ROB is clearing: retire nothing this cycle
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
        req_d   = 1'b0;
      end
    endcase
  end

  // combinational pop is forced low while reset is held
  assign pop_o     = pop & reset_ni;
  assign mem_req_o = req_q;

  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      state_q <= RUN;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

endmodule

// File: rtl/rob_commit_unit.sv
// In-order retirement: commits ROB head to regfile, flags, memory;
// raises a one-cycle flush with redirect PC on a mispredict.
// Ports: clk, reset (sync, active-low), head_* entry fields,
//   rob_pop, rf_*, flags_*, mem_* store port, flush, redirect_pc,
//   retired_count.
module rob_commit_unit
  import rob_pkg::*;
#(
  parameter int ROBsize = 8,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              head_valid,
  input  logic              head_done,
  input  logic              head_regWrite,
  input  logic [4:0]        head_rd,
  input  logic [DATA_W-1:0] head_value,
  input  logic              head_saveCond,
  input  logic [3:0]        head_flags,
  input  logic              head_isStore,
  input  logic [ADDR_W-1:0] head_stAddr,
  input  logic [DATA_W-1:0] head_stData,
  input  logic              head_mispredict,
  input  logic [ADDR_W-1:0] head_target,
  output logic              rob_pop,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              flags_we,
  output logic [3:0]        flags_o,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       retired_count
);

  if ((ROBsize & (ROBsize - 1)) != 0 ||
      DATA_W > XLEN || ADDR_W > XLEN) begin : g_bad_cfg
    $error("rob_commit_unit: unsupported parameters");
  end

  rob_entry_t head;

  always_comb begin
    head            = '0;
    head.valid      = head_valid;
    head.done       = head_done;
    head.reg_write  = head_regWrite;
    head.rd         = head_rd;
    head.value      = XLEN'(head_value);
    head.save_cond  = head_saveCond;
    head.flags      = head_flags;
    head.is_store   = head_isStore;
    head.st_addr    = XLEN'(head_stAddr);
    head.st_data    = XLEN'(head_stData);
    head.mispredict = head_mispredict;
    head.target     = XLEN'(head_target);
  end

  logic pop;
  logic st_start;

  commit_fsm u_fsm (
    .clk        (clk),
    .reset_ni   (reset),
    .rdy_i      (head.valid & head.done),
    .store_i    (head.is_store),
    .mis_i      (head.mispredict),
    .mem_ack_i  (mem_ack),
    .pop_o      (pop),
    .st_start_o (st_start),
    .mem_req_o  (mem_req)
  );

  assign rob_pop = pop;

  logic              rf_we_q, rf_we_d;
  logic [4:0]        waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              fwe_q, fwe_d;
  logic [3:0]        flags_q, flags_d;
  logic [ADDR_W-1:0] maddr_q;
  logic [DATA_W-1:0] mdata_q;
  logic              flush_q, flush_d;
  logic [ADDR_W-1:0] redir_q;
  logic [31:0]       cnt_q, cnt_d;

  always_comb begin
    flags_d         = '0;
    flags_d[FLAG_N] = head.flags[FLAG_N];
    flags_d[FLAG_Z] = head.flags[FLAG_Z];
    flags_d[FLAG_V] = head.flags[FLAG_V];
    flags_d[FLAG_C] = head.flags[FLAG_C];
    rf_we_d = pop & head.reg_write;
    fwe_d   = pop & head.save_cond;
    // stores are never mispredicted branches
    flush_d = pop & head.mispredict & ~head.is_store;
    cnt_d   = cnt_q + {31'd0, pop};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      fwe_q   <= 1'b0;
      flags_q <= '0;
      maddr_q <= '0;
      mdata_q <= '0;
      flush_q <= 1'b0;
      redir_q <= '0;
      cnt_q   <= '0;
    end else begin
      rf_we_q <= rf_we_d;
      fwe_q   <= fwe_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
      if (pop) begin
        waddr_q <= head.rd;
        wdata_q <= head.value[DATA_W-1:0];
        flags_q <= flags_d;
      end
      if (flush_d) redir_q <= head.target[ADDR_W-1:0];
      // address/data frozen for the whole request
      if (st_start) begin
        maddr_q <= head.st_addr[ADDR_W-1:0];
        mdata_q <= head.st_data[DATA_W-1:0];
      end
    end
  end

  assign rf_we         = rf_we_q;
  assign rf_waddr      = waddr_q;
  assign rf_wdata      = wdata_q;
  assign flags_we      = fwe_q;
  assign flags_o       = flags_q;
  assign mem_addr      = maddr_q;
  assign mem_wdata     = mdata_q;
  assign flush         = flush_q;
  assign redirect_pc   = redir_q;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Scoreboard bench for rob_commit_unit: directed test-plan entries
// plus randomized entries against a rule-level reference model.
module tb_rob_commit_unit;
  import rob_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        head_valid = 1'b0, head_done = 1'b0;
  logic        head_regWrite = 1'b0;
  logic [4:0]  head_rd = '0;
  logic [63:0] head_value = '0;
  logic        head_saveCond = 1'b0;
  logic [3:0]  head_flags = '0;
  logic        head_isStore = 1'b0;
  logic [63:0] head_stAddr = '0, head_stData = '0;
  logic        head_mispredict = 1'b0;
  logic [63:0] head_target = '0;
  logic        mem_ack = 1'b0;
  logic        rob_pop, rf_we, flags_we, mem_req, flush;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata, mem_addr, mem_wdata, redirect_pc;
  logic [3:0]  flags_o;
  logic [31:0] retired_count;

  always #5 clk = ~clk;

  rob_commit_unit dut (
    .clk(clk), .reset(reset),
    .head_valid(head_valid), .head_done(head_done),
    .head_regWrite(head_regWrite), .head_rd(head_rd),
    .head_value(head_value), .head_saveCond(head_saveCond),
    .head_flags(head_flags), .head_isStore(head_isStore),
    .head_stAddr(head_stAddr), .head_stData(head_stData),
    .head_mispredict(head_mispredict), .head_target(head_target),
    .rob_pop(rob_pop), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .flags_we(flags_we), .flags_o(flags_o),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .flush(flush), .redirect_pc(redirect_pc),
    .retired_count(retired_count)
  );

  typedef struct {
    bit rw; bit [4:0] rd; bit [63:0] val;
    bit sc; bit [3:0] fl;
    bit st; bit [63:0] addr; bit [63:0] data;
    bit mis; bit [63:0] tgt;
    int dly; int ackd;
  } ent_t;

  ent_t prog[$];
  ent_t exp_q[$];

  int vecs = 0;
  int errs = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic ent_t mk(bit rw, bit [4:0] rd, bit [63:0] v,
      bit sc, bit [3:0] fl, bit st, bit [63:0] a, bit [63:0] d,
      bit mis, bit [63:0] t, int dly, int ackd);
    ent_t e;
    e.rw = rw; e.rd = rd; e.val = v; e.sc = sc; e.fl = fl;
    e.st = st; e.addr = a; e.data = d; e.mis = mis; e.tgt = t;
    e.dly = dly; e.ackd = ackd;
    return e;
  endfunction

  // reference model state: retirement rules in terms of entries
  bit          mon_en = 0;
  bit          m_sw = 0, m_fl = 0;
  bit          e_rw = 0, e_fw = 0, e_flush = 0, e_mreq = 0;
  bit [4:0]    e_rd = '0;
  bit [63:0]   e_val = '0, e_tgt = '0, e_maddr = '0, e_mdata = '0;
  bit [3:0]    e_fl = '0;
  logic [31:0] mcount = '0;

  always @(negedge clk) begin
    if (head_valid)
      assert (!(head_isStore && head_mispredict))
        else $error("illegal mispredicted store at head");
  end

  always @(negedge clk) begin : monitor
    ent_t f;
    bit rdy, ep, sw_n;
    if (mon_en) begin
      f = (exp_q.size() > 0) ? exp_q[0] : mk(0,0,0,0,0,0,0,0,0,0,0,1);
      rdy = head_valid && head_done;
      ep = rdy && !m_fl && (m_sw ? mem_ack : !head_isStore);
      chk("rob_pop", rob_pop, ep);
      chk("rf_we", rf_we, e_rw);
      if (e_rw) begin
        chk("rf_waddr", rf_waddr, e_rd);
        chk("rf_wdata", rf_wdata, e_val);
      end
      chk("flags_we", flags_we, e_fw);
      if (e_fw) chk("flags_o", flags_o, e_fl);
      chk("flush", flush, e_flush);
      if (e_flush) chk("redirect_pc", redirect_pc, e_tgt);
      chk("mem_req", mem_req, e_mreq);
      if (e_mreq) begin
        chk("mem_addr", mem_addr, e_maddr);
        chk("mem_wdata", mem_wdata, e_mdata);
      end
      chk("retired_count", retired_count, mcount);
      sw_n = m_sw ? !mem_ack : (!m_fl && rdy && head_isStore);
      if (!m_sw && sw_n) begin
        e_maddr = f.addr;
        e_mdata = f.data;
      end
      e_rw = ep && f.rw;
      e_fw = ep && f.sc;
      e_flush = ep && f.mis && !f.st;
      if (ep) begin
        e_rd = f.rd; e_val = f.val; e_fl = f.fl;
        if (f.mis) e_tgt = f.tgt;
        mcount = mcount + 1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        else begin
          errs++;
          $display("FAIL scoreboard: pop with no entry queued");
        end
      end
      e_mreq = sw_n;
      m_sw = sw_n;
      m_fl = e_flush;
    end
  end

  task automatic idle(int n);
    head_valid = 0; head_done = 0; mem_ack = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_prog(int maxc);
    ent_t cur;
    bit have = 0, popped = 0;
    int cyc = 0, dd = 0, req_cnt = 0;
    cur = mk(0,0,0,0,0,0,0,0,0,0,0,1);
    while ((prog.size() > 0 || have) && cyc < maxc) begin
      @(negedge clk);
      popped = rob_pop;
      @(posedge clk);
      #1;
      cyc++;
      if (have && popped) have = 0;
      if (!have && prog.size() > 0) begin
        cur = prog.pop_front();
        have = 1;
        dd = cur.dly;
        req_cnt = 0;
        exp_q.push_back(cur);
      end
      head_valid = have;
      head_done = have && (dd == 0);
      if (dd > 0) dd--;
      head_regWrite = cur.rw; head_rd = cur.rd;
      head_value = cur.val; head_saveCond = cur.sc;
      head_flags = cur.fl; head_isStore = cur.st;
      head_stAddr = cur.addr; head_stData = cur.data;
      head_mispredict = cur.mis; head_target = cur.tgt;
      if (mem_req) begin
        req_cnt++;
        mem_ack = (req_cnt >= cur.ackd);
      end else begin
        req_cnt = 0;
        mem_ack = ($urandom_range(0, 7) == 0);
      end
    end
    if (cyc >= maxc) begin
      errs++;
      $display("FAIL run_timeout: %0d entries left after %0d cycles",
               prog.size(), cyc);
    end
    idle(2);
  endtask

  function automatic ent_t rnd_ent();
    ent_t e;
    int k;
    k = $urandom_range(0, 3);
    e = mk($urandom_range(0, 1), 5'($urandom), {$urandom, $urandom},
           $urandom_range(0, 1), 4'($urandom), 0, 0, 0, 0, 0,
           ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
           $urandom_range(1, 4));
    if (k == 1) begin
      e.st = 1;
      e.addr = {$urandom, $urandom};
      e.data = {$urandom, $urandom};
    end
    if (k == 2) begin
      e.mis = 1;
      e.tgt = {$urandom, $urandom};
    end
    return e;
  endfunction

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rob_pop", rob_pop, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_flags_we", flags_we, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_flush", flush, 0);
    chk("rst_count", retired_count, 0);
    reset = 1;
    mon_en = 1;

    // two back-to-back ALU entries
    prog.push_back(mk(1, 3, 'h10, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    prog.push_back(mk(1, 4, 'h20, 1, 4'b0100, 0, 0, 0, 0, 0, 0, 1));
    run_prog(50);
    chk("tp1_count", retired_count, 2);

    // store acked on the third request cycle
    prog.push_back(mk(0, 0, 0, 0, 0, 1, 'h80, 'hDEAD, 0, 0, 0, 3));
    run_prog(50);

    // mispredict, then a ready entry presented during FLUSH
    prog.push_back(mk(1, 7, 'h55, 0, 0, 0, 0, 0, 1, 'h400, 0, 1));
    prog.push_back(mk(1, 8, 'h66, 1, 4'h3, 0, 0, 0, 0, 0, 0, 1));
    run_prog(50);

    // head valid but not done for 5 cycles
    prog.push_back(mk(1, 9, 'h99, 1, 4'hA, 0, 0, 0, 0, 0, 5, 1));
    run_prog(50);

    // randomized stream
    for (int i = 0; i < 300; i++) prog.push_back(rnd_ent());
    run_prog(6000);

    // reset while a store is waiting for ack
    mon_en = 0;
    @(posedge clk);
    #1;
    head_valid = 1; head_done = 1; head_isStore = 1;
    head_mispredict = 0; head_regWrite = 1; head_saveCond = 1;
    head_stAddr = 'h123; head_stData = 'h456; mem_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sw_req_before", mem_req, 1);
    reset = 0;
    head_isStore = 0;
    #1;
    chk("rst_sw_pop_gated", rob_pop, 0);
    @(posedge clk);
    #1;
    chk("rst_sw_mem_req", mem_req, 0);
    chk("rst_sw_mem_addr", mem_addr, 0);
    chk("rst_sw_mem_wdata", mem_wdata, 0);
    chk("rst_sw_rf_we", rf_we, 0);
    chk("rst_sw_rf_waddr", rf_waddr, 0);
    chk("rst_sw_rf_wdata", rf_wdata, 0);
    chk("rst_sw_flags_we", flags_we, 0);
    chk("rst_sw_flags", flags_o, 0);
    chk("rst_sw_flush", flush, 0);
    chk("rst_sw_redirect", redirect_pc, 0);
    chk("rst_sw_count", retired_count, 0);
    chk("rst_sw_state", dut.u_fsm.state_q, RUN);
    head_valid = 0; head_done = 0; head_isStore = 0;
    reset = 1;
    m_sw = 0; m_fl = 0; e_rw = 0; e_fw = 0;
    e_flush = 0; e_mreq = 0; mcount = '0;
    exp_q.delete();
    idle(1);
    mon_en = 1;

    // counter wrap
    @(posedge clk);
    #2;
    force dut.cnt_q = 32'hFFFF_FFFF;
    mcount = 32'hFFFF_FFFF;
    @(posedge clk);
    #2;
    release dut.cnt_q;
    prog.push_back(mk(1, 1, 'h1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    run_prog(50);
    chk("wrap_count", retired_count, 0);

    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
